// File: rtl/level_hv_gen_if.sv
// Request/stream bundle for the thermometer-code generator.
// The master side issues counts and accepts mask words. The slave side is the generator.
interface level_hv_gen_if #(
    parameter int D  = 1024,
    parameter int W  = 64,
    parameter int CW = $clog2(D + 1)
);
    logic          req_valid;
    logic          req_ready;
    logic [CW-1:0] req_count;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          out_last;
    logic          busy;

    modport master (
        output req_valid, req_count, out_ready,
        input  req_ready, out_valid, out_word, out_last, busy
    );

    modport slave (
        input  req_valid, req_count, out_ready,
        output req_ready, out_valid, out_word, out_last, busy
    );
endinterface

// File: rtl/level_hv_gen.sv
// Streaming thermometer-code generator. It takes a count k and emits a D-bit
// vector, lowest word first. The lowest k bits of that vector are ones and all
// other bits are zeros.
// Every output is a register, so req_* has no combinational path to out_*.
module level_hv_gen #(
    parameter int D = 1024,
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    level_hv_gen_if.slave  bus
);
    localparam int CW = $clog2(D + 1);
    localparam int NW = D / W;
    localparam int JW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    // Mask word j for count k.
    // Comparing k against j*W before subtracting avoids any underflow.
    // Building the mask bit by bit also avoids a shift by W when the word is full.
    function automatic logic [W-1:0] word_of(input logic [CW-1:0] k, input logic [JW-1:0] j);
        logic [CW:0]  base;
        logic [CW:0]  rem;
        logic [W-1:0] m;
        m    = {W{1'b0}};
        rem  = {(CW+1){1'b0}};
        base = (CW+1)'(j) * (CW+1)'(W);
        if ({1'b0, k} <= base) begin
            m = {W{1'b0}};
        end else begin
            rem = {1'b0, k} - base;
            if (rem >= (CW+1)'(W)) begin
                m = {W{1'b1}};
            end else begin
                for (int b = 0; b < W; b++) begin
                    m[b] = ((CW+1)'(b) < rem);
                end
            end
        end
        return m;
    endfunction

    state_t        state_q,     state_d;
    logic [CW-1:0] k_q,         k_d;
    logic [JW-1:0] j_q,         j_d;
    logic          req_ready_q, req_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  out_word_q,  out_word_d;
    logic          out_last_q,  out_last_d;
    logic          busy_q,      busy_d;

    logic [CW-1:0] k_sat_s;
    logic          accept_s;
    logic          xfer_s;
    logic [JW-1:0] j_next_s;

    assign k_sat_s  = (bus.req_count > CW'(D)) ? CW'(D) : bus.req_count;
    assign accept_s = bus.req_valid & req_ready_q;
    assign xfer_s   = out_valid_q & bus.out_ready;
    assign j_next_s = j_q + {{(JW-1){1'b0}}, 1'b1};

    // State register and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_q         <= {CW{1'b0}};
            j_q         <= {JW{1'b0}};
            req_ready_q <= 1'b1;
            out_valid_q <= 1'b0;
            out_word_q  <= {W{1'b0}};
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            j_q         <= j_d;
            req_ready_q <= req_ready_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: an accepted request starts a stream, and the last transfer ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_STREAM;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (xfer_s && out_last_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_STREAM;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values. Everything holds unless a request is
    // accepted or a word is transferred, so a stall keeps the outputs stable.
    always_comb begin
        k_d         = k_q;
        j_d         = j_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    k_d         = k_sat_s;
                    j_d         = {JW{1'b0}};
                    out_valid_d = 1'b1;
                    out_word_d  = word_of(k_sat_s, {JW{1'b0}});
                    out_last_d  = (NW == 1);
                    busy_d      = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end
            S_STREAM: begin
                if (xfer_s && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_word_d  = {W{1'b0}};
                    out_last_d  = 1'b0;
                    busy_d      = 1'b0;
                end else if (xfer_s) begin
                    j_d        = j_next_s;
                    out_word_d = word_of(k_q, j_next_s);
                    out_last_d = (j_next_s == JW'(NW - 1));
                end else begin
                    out_word_d = out_word_q;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    assign bus.req_ready = req_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_word  = out_word_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_level_hv_gen.sv
// Scoreboard bench for level_hv_gen with D=256 and W=64.
// Stimulus pushes the expected words. A negedge monitor pops those words and compares them with the DUT output.
module tb_level_hv_gen;
    localparam int D  = 256;
    localparam int W  = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZERO = 64'h0000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    level_hv_gen_if #(.D(D), .W(W)) bus ();

    level_hv_gen #(.D(D), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [63:0] exp_w[$];
    bit          exp_l[$];
    int          exp_k[$];

    bit          bp_mode    = 1'b0;
    bit          b2b_chk    = 1'b0;
    bit          first_pend = 1'b0;
    bit          prev_stall = 1'b0;
    int          last_cyc   = -10;
    int          acc_pop    = 0;
    logic [63:0] prev_word;
    logic        prev_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    endtask

    function automatic logic [63:0] ref_word(input int ks, input int j);
        logic [63:0] w;
        for (int b = 0; b < 64; b++) w[b] = ((j * 64 + b) < ks);
        return w;
    endfunction

    task automatic push_stream(input logic [63:0] w0, input logic [63:0] w1,
                               input logic [63:0] w2, input logic [63:0] w3, input int k);
        exp_w.push_back(w0); exp_l.push_back(1'b0);
        exp_w.push_back(w1); exp_l.push_back(1'b0);
        exp_w.push_back(w2); exp_l.push_back(1'b0);
        exp_w.push_back(w3); exp_l.push_back(1'b1);
        exp_k.push_back(k);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int k, input bit hold);
        int t;
        t = 0;
        bus.req_valid = 1'b1;
        bus.req_count = k[8:0];
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            t++;
            if (t > 200) begin
                n_chk++;
                $display("FAIL accept_timeout: req_ready never high for k=%0d", k);
                break;
            end
        end
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_w.size() != 0 || bus.out_valid) && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 2000) begin
            n_chk++;
            $display("FAIL idle_timeout: %0d words still expected", exp_w.size());
        end
    endtask

    // Cycle counter used for latency and bubble checks.
    always @(posedge clk) cyc <= cyc + 1;

    // Backpressure driver: random when bp_mode is set, otherwise always ready.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: status invariants, stall stability, latency, bubble, word/last/popcount scoreboard.
    always @(negedge clk) begin : monitor
        logic [63:0] ew;
        bit          el;
        int          ek;
        if (rst) begin
            acc_pop    = 0;
            first_pend = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("busy_vs_valid", 64'(bus.busy), 64'(bus.out_valid));
            chk("ready_vs_valid", 64'(bus.req_ready), 64'(!bus.out_valid));
            if (prev_stall) begin
                chk("stall_word", bus.out_word, prev_word);
                chk("stall_last", 64'(bus.out_last), 64'(prev_last));
                chk("stall_valid", 64'(bus.out_valid), 64'(1));
            end
            if (first_pend) begin
                chk("first_latency", 64'(bus.out_valid), 64'(1));
                first_pend = 1'b0;
            end
            if (bus.req_valid && bus.req_ready) begin
                if (b2b_chk) chk("b2b_gap", 64'(cyc), 64'(last_cyc + 1));
                first_pend = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_w.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_word: got %h expected none", bus.out_word);
                end else begin
                    ew = exp_w.pop_front();
                    el = exp_l.pop_front();
                    chk("word", bus.out_word, ew);
                    chk("last", 64'(bus.out_last), 64'(el));
                    acc_pop += $countones(bus.out_word);
                    if (bus.out_last) begin
                        if (exp_k.size() != 0) begin
                            ek = exp_k.pop_front();
                            chk("popcount", 64'(acc_pop), 64'(ek));
                        end
                        acc_pop  = 0;
                        last_cyc = cyc;
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_word  = bus.out_word;
            prev_last  = bus.out_last;
        end
    end

    initial begin
        int k;
        bus.req_valid = 1'b0;
        bus.req_count = 9'd0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_word", bus.out_word, ZERO);
        chk("rst_out_last", 64'(bus.out_last), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready), 64'(1));

        // k=70: one full word, then six ones, then zeros.
        push_stream(ONES, 64'h0000_0000_0000_003F, ZERO, ZERO, 70);
        send(70, 1'b0);
        wait_idle();

        // Back-to-back requests with req_valid held high: 0, 256, 128.
        push_stream(ZERO, ZERO, ZERO, ZERO, 0);
        send(0, 1'b1);
        b2b_chk = 1'b1;
        push_stream(ONES, ONES, ONES, ONES, 256);
        send(256, 1'b1);
        push_stream(ONES, ONES, ZERO, ZERO, 128);
        send(128, 1'b0);
        wait_idle();
        b2b_chk = 1'b0;

        // k=64 under random backpressure.
        bp_mode = 1'b1;
        push_stream(ONES, ZERO, ZERO, ZERO, 64);
        send(64, 1'b0);
        wait_idle();
        bp_mode = 1'b0;

        // Count above D saturates to D.
        push_stream(ONES, ONES, ONES, ONES, 256);
        send(300, 1'b0);
        wait_idle();

        // Reset while the second word is valid.
        push_stream(ONES, ONES, ONES, 64'h0000_0000_0000_00FF, 200);
        send(200, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
        chk("abort_busy", 64'(bus.busy), 64'(0));
        chk("abort_req_ready", 64'(bus.req_ready), 64'(1));
        chk("abort_out_last", 64'(bus.out_last), 64'(0));
        exp_w.delete();
        exp_l.delete();
        exp_k.delete();
        rst = 1'b0;
        push_stream(64'h0000_0000_0000_0001, ZERO, ZERO, ZERO, 1);
        send(1, 1'b0);
        wait_idle();

        // Random counts under random backpressure.
        bp_mode = 1'b1;
        for (int s = 0; s < 1000; s++) begin
            k = $urandom_range(0, 256);
            push_stream(ref_word(k, 0), ref_word(k, 1), ref_word(k, 2), ref_word(k, 3), k);
            send(k, 1'b0);
        end
        wait_idle();
        bp_mode = 1'b0;
        chk("queue_empty", 64'(exp_w.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
